// File: rtl/shift_serdes_unit.sv
// Universal shift register with variable-amount shift/rotate ops and a
// framed serialiser/deserialiser that shifts d out while filling q.
// Ports: clk, reset_n, en, op, amt, msb_in, lsb_in, d, tx_start, tx_dir,
//        q, ser_out, tx_busy, tx_done.
module shift_serdes_unit #(
  parameter int WIDTH = 8,
  localparam int AW = $clog2(WIDTH),
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    amt,
  input  logic             msb_in,
  input  logic             lsb_in,
  input  logic [WIDTH-1:0] d,
  input  logic             tx_start,
  input  logic             tx_dir,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             tx_busy,
  output logic             tx_done
);

  typedef enum logic {
    IDLE,
    TX
  } state_t;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_SRL  = 3'b001,
    OP_SLL  = 3'b010,
    OP_LOAD = 3'b011,
    OP_ROR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_SRA  = 3'b110,
    OP_CLR  = 3'b111
  } op_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              dir;
  logic [WIDTH-1:0]  op_q;
  logic [WIDTH-1:0]  tx_q;
  logic [WIDTH-1:0]  r_mask;
  logic [WIDTH-1:0]  l_mask;
  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] rr;
  logic [2*WIDTH-1:0] rl;

  // Masks mark the bit positions vacated by a shift of amt.
  assign r_mask = ~(ONES >> amt);
  assign l_mask = ~(ONES << amt);
  assign dbl    = {q, q};
  assign rr     = dbl >> amt;
  assign rl     = dbl << amt;

  always_comb begin
    op_q = q;
    unique case (op_t'(op))
      OP_HOLD: op_q = q;
      OP_SRL:  op_q = (q >> amt) | ({WIDTH{msb_in}} & r_mask);
      OP_SLL:  op_q = (q << amt) | ({WIDTH{lsb_in}} & l_mask);
      OP_LOAD: op_q = d;
      OP_ROR:  op_q = rr[WIDTH-1:0];
      OP_ROL:  op_q = rl[2*WIDTH-1:WIDTH];
      OP_SRA:  op_q = (q >> amt) | ({WIDTH{q[WIDTH-1]}} & r_mask);
      OP_CLR:  op_q = '0;
      default: op_q = q;
    endcase
  end

  // One-bit transfer shift toward the output end.
  always_comb begin
    tx_q = q;
    if (dir) tx_q = {q[WIDTH-2:0], lsb_in};
    else     tx_q = {msb_in, q[WIDTH-1:1]};
  end

  assign ser_out = tx_busy & (dir ? q[WIDTH-1] : q[0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      q       <= '0;
      cnt     <= '0;
      dir     <= 1'b0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else if (en) begin
      tx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tx_start) begin
            state   <= TX;
            q       <= d;
            dir     <= tx_dir;
            cnt     <= '0;
            tx_busy <= 1'b1;
          end else begin
            q <= op_q;
          end
        end
        TX: begin
          q   <= tx_q;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state   <= IDLE;
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_serdes_unit.sv
// Directed bench for shift_serdes_unit (WIDTH=8): shift/rotate ops,
// framed transfers both directions, en stalls, priority, reset abort.
module tb_shift_serdes_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic [2:0] op;
  logic [2:0] amt;
  logic       msb_in;
  logic       lsb_in;
  logic [7:0] d;
  logic       tx_start;
  logic       tx_dir;
  logic [7:0] q;
  logic       ser_out;
  logic       tx_busy;
  logic       tx_done;

  int tests = 0;
  int fails = 0;

  shift_serdes_unit #(.WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .op(op), .amt(amt),
    .msb_in(msb_in), .lsb_in(lsb_in), .d(d), .tx_start(tx_start),
    .tx_dir(tx_dir), .q(q), .ser_out(ser_out), .tx_busy(tx_busy),
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] pat;
  logic [7:0] rx;

  initial begin
    reset_n = 1'b0; en = 1'b1; op = 3'b000; amt = '0;
    msb_in = 1'b0; lsb_in = 1'b0; d = '0;
    tx_start = 1'b0; tx_dir = 1'b0;
    #3;
    chk("rst_q", q, 8'h00);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    chk("rst_ser", ser_out, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // T1: load, SRA, ROL, ROR, SRL with fill
    op = 3'b011; d = 8'hA5; step();
    chk("load_a5", q, 8'hA5);
    op = 3'b110; amt = 3'd3; step();
    chk("sra3", q, 8'hF4);
    op = 3'b011; d = 8'h81; step();
    op = 3'b101; amt = 3'd1; step();
    chk("rol1", q, 8'h03);
    op = 3'b100; amt = 3'd1; step();
    chk("ror1", q, 8'h81);
    op = 3'b001; amt = 3'd2; msb_in = 1'b1; step();
    chk("srl2_fill1", q, 8'hE0);

    // T2: SLL with lsb fill, amt=0, hold, clear, en=0
    op = 3'b011; d = 8'h0F; step();
    op = 3'b010; amt = 3'd4; lsb_in = 1'b1; step();
    chk("sll4_fill1", q, 8'hFF);
    op = 3'b001; amt = 3'd0; msb_in = 1'b0; step();
    chk("srl0", q, 8'hFF);
    op = 3'b000; step();
    chk("hold", q, 8'hFF);
    op = 3'b111; step();
    chk("clear", q, 8'h00);
    en = 1'b0; op = 3'b011; d = 8'h77; step();
    chk("en0_hold", q, 8'h00);
    en = 1'b1; op = 3'b000; lsb_in = 1'b0;

    // T3: LSB-first frame, msb_in=1
    pat = 8'hB4; d = pat; tx_dir = 1'b0; msb_in = 1'b1; tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t3_ser%0d", k), ser_out, pat[k]);
      chk($sformatf("t3_busy%0d", k), tx_busy, 1'b1);
      step();
    end
    chk("t3_busy_end", tx_busy, 1'b0);
    chk("t3_done", tx_done, 1'b1);
    chk("t3_q", q, 8'hFF);
    step();
    chk("t3_done_clr", tx_done, 1'b0);

    // T4: MSB-first frame, receive 5A, stall with en=0 mid-frame
    pat = 8'hC3; rx = 8'h5A; d = pat; tx_dir = 1'b1; tx_start = 1'b1;
    step();
    tx_start = 1'b0; tx_dir = 1'b0;
    for (int k = 0; k < 8; k++) begin
      lsb_in = rx[7-k];
      chk($sformatf("t4_ser%0d", k), ser_out, pat[7-k]);
      if (k == 3) begin
        en = 1'b0;
        step(); step();
        chk("t4_stall_ser", ser_out, pat[7-k]);
        chk("t4_stall_busy", tx_busy, 1'b1);
        en = 1'b1;
      end
      step();
    end
    chk("t4_done", tx_done, 1'b1);
    chk("t4_q", q, 8'h5A);
    en = 1'b0; step();
    chk("t4_done_stretch", tx_done, 1'b1);
    en = 1'b1; step();
    chk("t4_done_clr", tx_done, 1'b0);

    // T5: tx_start beats op=clear; op ignored during TX
    op = 3'b111; d = 8'h3C; tx_start = 1'b1; msb_in = 1'b0; step();
    tx_start = 1'b0;
    chk("t5_no_clear", q, 8'h3C);
    chk("t5_busy", tx_busy, 1'b1);
    op = 3'b011; d = 8'hFF; step();
    chk("t5_op_ignored", q, 8'h1E);
    for (int k = 0; k < 7; k++) step();
    chk("t5_done", tx_done, 1'b1);
    chk("t5_q", q, 8'h00);
    op = 3'b000;

    // T6: reset mid-frame, then back-to-back frames
    d = 8'hB4; tx_start = 1'b1; step();
    tx_start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    reset_n = 1'b0; #1;
    chk("t6_rst_q", q, 8'h00);
    chk("t6_rst_busy", tx_busy, 1'b0);
    chk("t6_rst_done", tx_done, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    d = 8'h0F; tx_start = 1'b1; step();
    tx_start = 1'b0;
    for (int k = 0; k < 8; k++) step();
    chk("t6_f1_done", tx_done, 1'b1);
    d = 8'hF0; tx_start = 1'b1; step();
    tx_start = 1'b0;
    chk("t6_f2_done_clr", tx_done, 1'b0);
    chk("t6_f2_busy", tx_busy, 1'b1);
    chk("t6_f2_q", q, 8'hF0);
    for (int k = 0; k < 8; k++) step();
    chk("t6_f2_done", tx_done, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
